// File: rtl/axis_frame_sync_ctrl.sv
// Frame-synchronising controller for two AXI4-Stream video inputs.
// Drops beats on each stream until both present start-of-frame together,
// then forwards them as one lockstep paired stream with zero latency.
// Any disagreement on tlast/SOF between the streams forces a resync.
//
// Ports:
//   axis_clk, areset      - clock, synchronous active-high reset
//   enable                - run request
//   s_axis_*_vid0/vid1    - the two video inputs
//   m_axis_*              - paired output (tdata per stream, shared tvalid/tready/tlast/tuser)
//   locked                - high while paired streaming is active
//   err_mismatch          - one-cycle pulse on a tlast/SOF disagreement
//   err_timeout           - one-cycle pulse every TIMEOUT cycles spent waiting for a dual SOF
//   resync_count          - saturating count of disagreements
//   frame_lines           - line count of the last complete frame
module axis_frame_sync_ctrl #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                  axis_clk,
    input  logic                  areset,
    input  logic                  enable,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata_vid0,
    input  logic                  s_axis_tvalid_vid0,
    output logic                  s_axis_tready_vid0,
    input  logic                  s_axis_tlast_vid0,
    input  logic [USER_WIDTH-1:0] s_axis_tuser_vid0,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata_vid1,
    input  logic                  s_axis_tvalid_vid1,
    output logic                  s_axis_tready_vid1,
    input  logic                  s_axis_tlast_vid1,
    input  logic [USER_WIDTH-1:0] s_axis_tuser_vid1,

    output logic [DATA_WIDTH-1:0] m_axis_tdata_vid0,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_vid1,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,

    output logic                  locked,
    output logic                  err_mismatch,
    output logic                  err_timeout,
    output logic [7:0]            resync_count,
    output logic [15:0]           frame_lines
);

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned RESYNC_W = 8;

    localparam logic [CNT_W-1:0]    WAIT_MAX   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    LINE_MAX   = '1;
    localparam logic [RESYNC_W-1:0] RESYNC_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]    line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0]    frame_lines_q, frame_lines_d;
    logic [RESYNC_W-1:0] resync_q, resync_d;
    logic                sof_seen_q, sof_seen_d;
    logic                locked_q, locked_d;
    logic                err_mm_q, err_mm_d;
    logic                err_to_q, err_to_d;

    logic sof0, sof1, match, both_valid, xfer;

    assign sof0       = s_axis_tuser_vid0[0];
    assign sof1       = s_axis_tuser_vid1[0];
    assign both_valid = s_axis_tvalid_vid0 & s_axis_tvalid_vid1;
    assign match      = (s_axis_tlast_vid0 == s_axis_tlast_vid1) && (sof0 == sof1);

    // Payload is a straight pass-through; only the handshake is gated.
    assign m_axis_tdata_vid0 = s_axis_tdata_vid0;
    assign m_axis_tdata_vid1 = s_axis_tdata_vid1;
    assign m_axis_tlast      = s_axis_tlast_vid0;
    assign m_axis_tuser      = s_axis_tuser_vid0;

    // Next-state, counters and handshake.
    always_comb begin
        state_d            = state_q;
        wait_cnt_d         = '0;
        line_cnt_d         = line_cnt_q;
        frame_lines_d      = frame_lines_q;
        resync_d           = resync_q;
        sof_seen_d         = 1'b0;
        err_mm_d           = 1'b0;
        err_to_d           = 1'b0;
        s_axis_tready_vid0 = 1'b0;
        s_axis_tready_vid1 = 1'b0;
        m_axis_tvalid      = 1'b0;
        xfer               = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                // Discard non-SOF beats; park an SOF beat until its partner shows up.
                s_axis_tready_vid0 = ~(s_axis_tvalid_vid0 & sof0);
                s_axis_tready_vid1 = ~(s_axis_tvalid_vid1 & sof1);

                if (wait_cnt_q == WAIT_MAX) begin
                    err_to_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end

                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (both_valid && sof0 && sof1) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                sof_seen_d         = sof_seen_q;
                m_axis_tvalid      = both_valid & match;
                s_axis_tready_vid0 = m_axis_tready & s_axis_tvalid_vid1 & match;
                s_axis_tready_vid1 = m_axis_tready & s_axis_tvalid_vid0 & match;
                xfer               = m_axis_tvalid & m_axis_tready;

                if (both_valid && !match) begin
                    err_mm_d = 1'b1;
                    state_d  = ST_FLUSH;
                    if (resync_q != RESYNC_MAX) begin
                        resync_d = resync_q + RESYNC_W'(1);
                    end
                end

                if (xfer) begin
                    if (sof0) begin
                        // The first SOF after locking starts counting; later ones close a frame.
                        if (sof_seen_q) begin
                            frame_lines_d = line_cnt_q;
                        end
                        sof_seen_d = 1'b1;
                        line_cnt_d = CNT_W'(s_axis_tlast_vid0);
                    end else if (s_axis_tlast_vid0 && (line_cnt_q != LINE_MAX)) begin
                        line_cnt_d = line_cnt_q + CNT_W'(1);
                    end

                    // A stop request is honoured only at a line boundary.
                    if (s_axis_tlast_vid0 && !enable) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        locked_d = (state_d == ST_RUN);
    end

    // State and status registers.
    always_ff @(posedge axis_clk) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            line_cnt_q    <= '0;
            frame_lines_q <= '0;
            resync_q      <= '0;
            sof_seen_q    <= 1'b0;
            locked_q      <= 1'b0;
            err_mm_q      <= 1'b0;
            err_to_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            line_cnt_q    <= line_cnt_d;
            frame_lines_q <= frame_lines_d;
            resync_q      <= resync_d;
            sof_seen_q    <= sof_seen_d;
            locked_q      <= locked_d;
            err_mm_q      <= err_mm_d;
            err_to_q      <= err_to_d;
        end
    end

    assign locked       = locked_q;
    assign err_mismatch = err_mm_q;
    assign err_timeout  = err_to_q;
    assign resync_count = resync_q;
    assign frame_lines  = frame_lines_q;

endmodule
